// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, requester ids and access counter sizing.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with a registered last-grant id.
// Ports: clk_i/rst_i, req_i[1:0], grant_en_i -> gnt_o[1:0] (one-hot), last_o.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == REQ_DBG) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (grant_en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? REQ_DBG : REQ_CPU;
        end
    end

    // Reset to the debug id so the CPU takes the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= REQ_DBG;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU and a debug/DMA
// port: round-robin grant, fixed-latency access, done pulse, CPU stall.
// Ports: clk_i, rst_i; cpu_* and dbg_* request sets (req/we/addr/wdata in,
//        rdata/done out); cpu_stall_o; mem_en/we/addr/wdata out, mem_rdata_i.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_done_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic [1:0] gnt;
    logic       grant_en;
    logic       win_id;
    logic       unused_addr_lo;

    assign grant_en = (state_q == ST_IDLE) && (cpu_req_i || dbg_req_i);

    // The picker's last-grant register doubles as the latched winner id,
    // since it is loaded on the same edge that starts the access.
    rr_arb2 u_rr_arb2 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      ({dbg_req_i, cpu_req_i}),
        .grant_en_i (grant_en),
        .gnt_o      (gnt),
        .last_o     (win_id)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    we_d    = gnt[1] ? dbg_we_i    : cpu_we_i;
                    addr_d  = gnt[1] ? dbg_addr_i  : cpu_addr_i;
                    wdata_d = gnt[1] ? dbg_wdata_i : cpu_wdata_i;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (win_id == REQ_DBG) begin
                            dbg_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Byte offset is dropped; the memory is word addressed.
    assign unused_addr_lo = ^addr_q[1:0];

    assign mem_en_o    = (state_q == ST_ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = wdata_q;

    assign cpu_done_o  = (state_q == ST_DONE) && (win_id == REQ_CPU);
    assign dbg_done_o  = (state_q == ST_DONE) && (win_id == REQ_DBG);
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;

    // Low in the done cycle so the CPU commits on that edge.
    assign cpu_stall_o = cpu_req_i && !cpu_done_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 with MEM_LAT=1,
// instance 1 with MEM_LAT=3, sharing clock and reset.
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_done  [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_wdata [2];
    logic [31:0] dbg_rdata [2];
    logic        dbg_done  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int ntests;
    int nfail;

    dmem_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req[0]),
        .cpu_we_i    (cpu_we[0]),
        .cpu_addr_i  (cpu_addr[0]),
        .cpu_wdata_i (cpu_wdata[0]),
        .cpu_rdata_o (cpu_rdata[0]),
        .cpu_done_o  (cpu_done[0]),
        .cpu_stall_o (cpu_stall[0]),
        .dbg_req_i   (dbg_req[0]),
        .dbg_we_i    (dbg_we[0]),
        .dbg_addr_i  (dbg_addr[0]),
        .dbg_wdata_i (dbg_wdata[0]),
        .dbg_rdata_o (dbg_rdata[0]),
        .dbg_done_o  (dbg_done[0]),
        .mem_en_o    (mem_en[0]),
        .mem_we_o    (mem_we[0]),
        .mem_addr_o  (mem_addr[0]),
        .mem_wdata_o (mem_wdata[0]),
        .mem_rdata_i (mem_rdata[0])
    );

    dmem_arbiter #(.MEM_LAT(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req[1]),
        .cpu_we_i    (cpu_we[1]),
        .cpu_addr_i  (cpu_addr[1]),
        .cpu_wdata_i (cpu_wdata[1]),
        .cpu_rdata_o (cpu_rdata[1]),
        .cpu_done_o  (cpu_done[1]),
        .cpu_stall_o (cpu_stall[1]),
        .dbg_req_i   (dbg_req[1]),
        .dbg_we_i    (dbg_we[1]),
        .dbg_addr_i  (dbg_addr[1]),
        .dbg_wdata_i (dbg_wdata[1]),
        .dbg_rdata_o (dbg_rdata[1]),
        .dbg_done_o  (dbg_done[1]),
        .mem_en_o    (mem_en[1]),
        .mem_we_o    (mem_we[1]),
        .mem_addr_o  (mem_addr[1]),
        .mem_wdata_o (mem_wdata[1]),
        .mem_rdata_i (mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input int k, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
        cpu_req[k]   = req;
        cpu_we[k]    = we;
        cpu_addr[k]  = addr;
        cpu_wdata[k] = wd;
    endtask

    task automatic set_dbg(input int k, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
        dbg_req[k]   = req;
        dbg_we[k]    = we;
        dbg_addr[k]  = addr;
        dbg_wdata[k] = wd;
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_cpu(k, 1'b0, 1'b0, 32'h0, 32'h0);
            set_dbg(k, 1'b0, 1'b0, 32'h0, 32'h0);
            mem_rdata[k] = 32'h0;
        end
        step();
        step();

        // Reset values on both instances
        for (int k = 0; k < 2; k++) begin
            check("rst_cpu_done",  {31'b0, cpu_done[k]}, 32'h0);
            check("rst_dbg_done",  {31'b0, dbg_done[k]}, 32'h0);
            check("rst_cpu_rdata", cpu_rdata[k], 32'h0);
            check("rst_dbg_rdata", dbg_rdata[k], 32'h0);
            check("rst_mem_en",    {31'b0, mem_en[k]}, 32'h0);
            check("rst_mem_we",    {31'b0, mem_we[k]}, 32'h0);
            check("rst_mem_addr",  mem_addr[k], 32'h0);
            check("rst_mem_wdata", mem_wdata[k], 32'h0);
        end
        rst = 1'b0;
        step();

        // Tie right after reset (MEM_LAT=1): CPU, then debug
        set_cpu(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_dbg(0, 1'b1, 1'b1, 32'h40, 32'hAA);
        mem_rdata[0] = 32'h5555;
        #1;
        check("tie1_stall", {31'b0, cpu_stall[0]}, 32'h1);
        step();
        check("tie1_en",   {31'b0, mem_en[0]}, 32'h1);
        check("tie1_addr", mem_addr[0], 32'h20);
        check("tie1_we",   {31'b0, mem_we[0]}, 32'h0);
        step();
        check("tie1_cdone", {31'b0, cpu_done[0]}, 32'h1);
        check("tie1_ddone", {31'b0, dbg_done[0]}, 32'h0);
        check("tie1_rdata", cpu_rdata[0], 32'h5555);
        check("tie1_en_d",  {31'b0, mem_en[0]}, 32'h0);
        check("tie1_stl_d", {31'b0, cpu_stall[0]}, 32'h0);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("tie1_idle_en", {31'b0, mem_en[0]}, 32'h0);
        check("tie1_idle_dn", {31'b0, cpu_done[0]}, 32'h0);
        step();
        check("tie1_dbg_addr", mem_addr[0], 32'h40);
        check("tie1_dbg_we",   {31'b0, mem_we[0]}, 32'h1);
        check("tie1_dbg_wd",   mem_wdata[0], 32'hAA);
        step();
        check("tie1_dbg_done", {31'b0, dbg_done[0]}, 32'h1);
        check("tie1_dbg_rd",   dbg_rdata[0], 32'h0);

        // Second tie: debug was granted last, so CPU wins
        set_cpu(0, 1'b1, 1'b0, 32'h24, 32'h0);
        set_dbg(0, 1'b1, 1'b0, 32'h44, 32'h0);
        mem_rdata[0] = 32'h6666;
        step();
        step();
        check("tie2_addr", mem_addr[0], 32'h24);
        step();
        check("tie2_cdone", {31'b0, cpu_done[0]}, 32'h1);
        check("tie2_rdata", cpu_rdata[0], 32'h6666);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check("tie2_dbg_addr", mem_addr[0], 32'h44);
        step();
        check("tie2_dbg_done", {31'b0, dbg_done[0]}, 32'h1);
        check("tie2_dbg_rd",   dbg_rdata[0], 32'h6666);
        set_dbg(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Single CPU load, MEM_LAT=1
        set_cpu(0, 1'b1, 1'b0, 32'h10, 32'h0);
        mem_rdata[0] = 32'h1234;
        #1;
        check("ld_stall0", {31'b0, cpu_stall[0]}, 32'h1);
        step();
        check("ld_en",     {31'b0, mem_en[0]}, 32'h1);
        check("ld_addr",   mem_addr[0], 32'h10);
        check("ld_stall1", {31'b0, cpu_stall[0]}, 32'h1);
        check("ld_done0",  {31'b0, cpu_done[0]}, 32'h0);
        step();
        check("ld_done",   {31'b0, cpu_done[0]}, 32'h1);
        check("ld_rdata",  cpu_rdata[0], 32'h1234);
        check("ld_stall2", {31'b0, cpu_stall[0]}, 32'h0);
        check("ld_en_off", {31'b0, mem_en[0]}, 32'h0);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("ld_done_end", {31'b0, cpu_done[0]}, 32'h0);
        check("ld_rd_hold",  cpu_rdata[0], 32'h1234);

        // Debug store, MEM_LAT=3, unaligned address
        set_dbg(1, 1'b1, 1'b1, 32'h1F, 32'hDEADBEEF);
        mem_rdata[1] = 32'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_en",   {31'b0, mem_en[1]}, 32'h1);
            check("st_addr", mem_addr[1], 32'h1C);
            check("st_we",   {31'b0, mem_we[1]}, 32'h1);
            check("st_wd",   mem_wdata[1], 32'hDEADBEEF);
            check("st_dn0",  {31'b0, dbg_done[1]}, 32'h0);
        end
        step();
        check("st_done",  {31'b0, dbg_done[1]}, 32'h1);
        check("st_rdata", dbg_rdata[1], 32'h0);
        check("st_en_d",  {31'b0, mem_en[1]}, 32'h0);
        set_dbg(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // CPU holds its request for three back-to-back loads
        set_cpu(1, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mem_rdata[1] = 32'h11 * (i + 1);
            cpu_addr[1]  = 32'h100 + 32'(4 * i);
            step();
            step();
            step();
            check("b2b_addr",  mem_addr[1], 32'h100 + 32'(4 * i));
            check("b2b_dn0",   {31'b0, cpu_done[1]}, 32'h0);
            step();
            check("b2b_done",  {31'b0, cpu_done[1]}, 32'h1);
            check("b2b_rdata", cpu_rdata[1], 32'h11 * (i + 1));
            step();
            check("b2b_idle",  {31'b0, cpu_done[1]}, 32'h0);
            check("b2b_stall", {31'b0, cpu_stall[1]}, 32'h1);
        end
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Reset in the second ACCESS cycle
        set_cpu(1, 1'b1, 1'b0, 32'h500, 32'h0);
        set_dbg(1, 1'b1, 1'b0, 32'h600, 32'h0);
        mem_rdata[1] = 32'h9;
        step();
        check("rm_dbg_win", mem_addr[1], 32'h600);
        step();
        rst = 1'b1;
        step();
        check("rm_en",    {31'b0, mem_en[1]}, 32'h0);
        check("rm_ddone", {31'b0, dbg_done[1]}, 32'h0);
        check("rm_cdone", {31'b0, cpu_done[1]}, 32'h0);
        check("rm_addr",  mem_addr[1], 32'h0);
        check("rm_crd",   cpu_rdata[1], 32'h0);
        rst = 1'b0;
        step();
        check("rm_cpu_win", mem_addr[1], 32'h500);
        step();
        step();
        check("rm_ddone2", {31'b0, dbg_done[1]}, 32'h0);
        step();
        check("rm_cdone2", {31'b0, cpu_done[1]}, 32'h1);
        check("rm_crd2",   cpu_rdata[1], 32'h9);
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Debug arrives during a CPU access and waits
        set_cpu(1, 1'b1, 1'b0, 32'h200, 32'h0);
        mem_rdata[1] = 32'h99;
        step();
        set_dbg(1, 1'b1, 1'b0, 32'h300, 32'h0);
        step();
        check("late_addr1", mem_addr[1], 32'h200);
        step();
        check("late_addr2", mem_addr[1], 32'h200);
        step();
        check("late_cdone", {31'b0, cpu_done[1]}, 32'h1);
        check("late_ddn0",  {31'b0, dbg_done[1]}, 32'h0);
        check("late_crd",   cpu_rdata[1], 32'h99);
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata[1] = 32'hABCD;
        step();
        check("late_idle", {31'b0, mem_en[1]}, 32'h0);
        step();
        check("late_daddr", mem_addr[1], 32'h300);
        step();
        step();
        step();
        check("late_ddone", {31'b0, dbg_done[1]}, 32'h1);
        check("late_drd",   dbg_rdata[1], 32'hABCD);
        set_dbg(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
